// File: rtl/clk_period_meter.sv
// Slow-signal period meter: synchronizes sig_in, emits rise/fall ticks, measures period and high time.
// Optional glitch filter enabled by defining CLK_METER_GLITCH_FILTER_EN.
module clk_period_meter #(
  parameter int MAX_PERIOD  = 1024,
  parameter int SYNC_STAGES = 2,
  parameter int TOLERANCE   = 0,
  parameter int FILTER_LEN  = 3,
  localparam int W = $clog2(MAX_PERIOD + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sig_in,
  output logic         rise_tick,
  output logic         fall_tick,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         period_valid,
  output logic         timeout,
  output logic         locked
);

  if (SYNC_STAGES < 2 || FILTER_LEN < 2) begin : g_bad_params
    $error("clk_period_meter: SYNC_STAGES and FILTER_LEN must be at least 2");
  end

`ifdef CLK_METER_GLITCH_FILTER_EN
  localparam int FILL = SYNC_STAGES + FILTER_LEN - 1;
`else
  localparam int FILL = SYNC_STAGES;
`endif

  typedef enum logic [1:0] {ST_ARM, ST_WAIT_FIRST, ST_COUNT, ST_TIMEOUT} state_t;

  state_t             state, next_state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               s;
  logic               p;
  logic               level;
  logic [FILL-1:0]    fill_q;
  logic               primed;
  logic [W-1:0]       pcnt, hcnt;
  logic               fall_seen;
  logic               have_prev;
  logic [W:0]         diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // The reset value of the synchronizer is not a real sample, so ARM only
  // trusts the level once every stage feeding it has been refilled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fill_q <= '0;
    else        fill_q <= {fill_q[FILL-2:0], 1'b1};
  end

  assign primed = fill_q[FILL-1];

`ifdef CLK_METER_GLITCH_FILTER_EN
  logic [FILTER_LEN-2:0] hist_q;
  logic [FILTER_LEN-1:0] win;

  assign win = {hist_q, s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= '0;
    else        hist_q <= win[FILTER_LEN-2:0];
  end

  // p already holds the previous filtered level, so it doubles as the filter state.
  always_comb begin
    level = p;
    if (&win)       level = 1'b1;
    else if (~|win) level = 1'b0;
  end
`else
  assign level = s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p         <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      p         <= level;
      rise_tick <= level & ~p & (state != ST_ARM);
      fall_tick <= ~level & p & (state != ST_ARM);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ARM;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_ARM:        if (primed && !level) next_state = ST_WAIT_FIRST;
      ST_WAIT_FIRST: if (rise_tick) next_state = ST_COUNT;
      ST_COUNT:      if (!rise_tick && pcnt == W'(MAX_PERIOD)) next_state = ST_TIMEOUT;
      ST_TIMEOUT:    if (rise_tick) next_state = ST_COUNT;
      default:       next_state = ST_ARM;
    endcase
  end

  always_comb begin
    if (pcnt >= period) diff = {1'b0, pcnt} - {1'b0, period};
    else                diff = {1'b0, period} - {1'b0, pcnt};
  end

  // period still holds the previous valid measurement when a new rise arrives,
  // so it serves as the lock reference; have_prev blocks the first compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt         <= '0;
      hcnt         <= '0;
      fall_seen    <= 1'b0;
      have_prev    <= 1'b0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      locked       <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state)
        ST_WAIT_FIRST: begin
          if (rise_tick) begin
            pcnt      <= W'(1);
            hcnt      <= W'(1);
            fall_seen <= 1'b0;
            have_prev <= 1'b0;
          end
        end
        ST_COUNT: begin
          if (rise_tick) begin
            period       <= pcnt;
            high_time    <= hcnt;
            period_valid <= 1'b1;
            if (have_prev) locked <= (diff <= (W+1)'(TOLERANCE));
            have_prev    <= 1'b1;
            pcnt         <= W'(1);
            hcnt         <= W'(1);
            fall_seen    <= 1'b0;
          end else if (pcnt == W'(MAX_PERIOD)) begin
            timeout <= 1'b1;
            locked  <= 1'b0;
          end else begin
            pcnt <= pcnt + W'(1);
            if (!fall_seen && !fall_tick) hcnt <= hcnt + W'(1);
            if (fall_tick) fall_seen <= 1'b1;
          end
        end
        ST_TIMEOUT: begin
          if (rise_tick) begin
            timeout   <= 1'b0;
            pcnt      <= W'(1);
            hcnt      <= W'(1);
            fall_seen <= 1'b0;
            have_prev <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed self-checking bench for clk_period_meter (MAX_PERIOD=16; tolerance 1 and 2 instances).
module tb_clk_period_meter;

  localparam int MAXP = 16;
  localparam int SYNC = 2;
  localparam int FLEN = 3;
  localparam int W    = $clog2(MAXP + 1);
`ifdef CLK_METER_GLITCH_FILTER_EN
  localparam int LAT         = SYNC + FLEN - 1;
  localparam int SHORT_TICKS = 0;
`else
  localparam int LAT         = SYNC;
  localparam int SHORT_TICKS = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic         sig_in;
  logic         rise1, fall1, pv1, to1, lock1;
  logic [W-1:0] period1, high1;
  logic         rise2, fall2, pv2, to2, lock2;
  logic [W-1:0] period2, high2;

  clk_period_meter #(
    .MAX_PERIOD(MAXP), .SYNC_STAGES(SYNC), .TOLERANCE(1), .FILTER_LEN(FLEN)
  ) u_tol1 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in),
    .rise_tick(rise1), .fall_tick(fall1), .period(period1), .high_time(high1),
    .period_valid(pv1), .timeout(to1), .locked(lock1)
  );

  clk_period_meter #(
    .MAX_PERIOD(MAXP), .SYNC_STAGES(SYNC), .TOLERANCE(2), .FILTER_LEN(FLEN)
  ) u_tol2 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in),
    .rise_tick(rise2), .fall_tick(fall2), .period(period2), .high_time(high2),
    .period_valid(pv2), .timeout(to2), .locked(lock2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int check_count = 0;
  int fail_count  = 0;
  int cyc         = 0;
  int start_cyc   = 0;
  int rise_count  = 0;
  int fall_count  = 0;
  int pv_count    = 0;
  int to_count    = 0;
  int to_cyc      = 0;
  int to_lock2    = 0;
  logic to_prev   = 1'b0;
  int rise_cyc [64];
  int pv_cyc   [64];
  int pv_period[64];
  int pv_high  [64];
  int pv_lock  [64];

  // Event recorder for u_tol1, sampling 1 time unit after each rising clock edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rise1) begin
      if (rise_count < 64) rise_cyc[rise_count] = cyc;
      rise_count++;
    end
    if (fall1) fall_count++;
    if (pv1) begin
      if (pv_count < 64) begin
        pv_cyc[pv_count]    = cyc;
        pv_period[pv_count] = int'(period1);
        pv_high[pv_count]   = int'(high1);
        pv_lock[pv_count]   = int'(lock1);
      end
      pv_count++;
    end
    if (to1 && !to_prev) begin
      to_cyc   = cyc;
      to_lock2 = int'(lock2);
      to_count++;
    end
    to_prev = to1;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One rep = high for high_cyc clocks then low for low_cyc clocks, so the
  // period between successive accepted rises equals high_cyc + low_cyc.
  task automatic applyStimulus(input int high_cyc, input int low_cyc, input int reps);
    for (int r = 0; r < reps; r++) begin
      @(negedge clk);
      sig_in = 1'b1;
      if (r == 0) start_cyc = cyc;
      repeat (high_cyc - 1) @(negedge clk);
      @(negedge clk);
      sig_in = 1'b0;
      repeat (low_cyc - 1) @(negedge clk);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pv_before;
    int rise_before;
    int fall_before;

    rst_n  = 1'b0;
    sig_in = 1'b1;
    waitCycles(3);
    checkOutput("reset_rise",      int'(rise1),   0);
    checkOutput("reset_fall",      int'(fall1),   0);
    checkOutput("reset_period",    int'(period1), 0);
    checkOutput("reset_high",      int'(high1),   0);
    checkOutput("reset_pv",        int'(pv1),     0);
    checkOutput("reset_timeout",   int'(to1),     0);
    checkOutput("reset_locked",    int'(lock1),   0);
    checkOutput("reset_u2_ticks",  int'(rise2) + int'(fall2) + int'(pv2), 0);
    checkOutput("reset_u2_high",   int'(high2),   0);

    @(negedge clk);
    rst_n = 1'b1;
    waitCycles(8);
    checkOutput("arm_high_no_rise", rise_count, 0);
    @(negedge clk);
    sig_in = 1'b0;
    waitCycles(6);
    checkOutput("arm_low_no_rise", rise_count, 0);
    checkOutput("arm_low_no_fall", fall_count, 0);

    // Square wave: period 10, high 5, six rising edges.
    applyStimulus(5, 5, 6);
    checkOutput("first_rise_latency", rise_cyc[0] - start_cyc, LAT + 1);
    checkOutput("rise_count_6", rise_count, 6);
    checkOutput("pv_count_5", pv_count, 5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("pv%0d_period", i), pv_period[i], 10);
      checkOutput($sformatf("pv%0d_high", i), pv_high[i], 5);
      checkOutput($sformatf("pv%0d_latency", i), pv_cyc[i] - rise_cyc[i + 1], 1);
    end
    checkOutput("lock_first_pv", pv_lock[0], 0);
    checkOutput("lock_second_pv", pv_lock[1], 1);
    checkOutput("lock_last_pv", pv_lock[4], 1);

    // Periods 10 then 12: tolerance 1 drops lock, tolerance 2 keeps it.
    applyStimulus(5, 7, 1);
    applyStimulus(5, 5, 1);
    checkOutput("p12_period", int'(period1), 12);
    checkOutput("p12_high", int'(high1), 5);
    checkOutput("p12_tol1_unlocked", int'(lock1), 0);
    checkOutput("p12_tol2_locked", int'(lock2), 1);
    checkOutput("p12_tol2_period", int'(period2), 12);

    // Hold low past MAX_PERIOD.
    waitCycles(25);
    checkOutput("timeout_u1", int'(to1), 1);
    checkOutput("timeout_u2", int'(to2), 1);
    checkOutput("timeout_count", to_count, 1);
    checkOutput("timeout_latency", to_cyc - rise_cyc[rise_count - 1], MAXP + 1);
    checkOutput("timeout_clears_lock", to_lock2, 0);
    checkOutput("timeout_u2_unlocked", int'(lock2), 0);
    checkOutput("timeout_period_held", int'(period1), 12);

    pv_before = pv_count;
    applyStimulus(5, 5, 1);
    checkOutput("timeout_cleared", int'(to1), 0);
    checkOutput("no_pv_after_timeout", pv_count, pv_before);

    applyStimulus(8, 8, 1);
    checkOutput("post_timeout_period", int'(period1), 10);
    checkOutput("post_timeout_no_lock", int'(lock2), 0);

    // Exactly MAX_PERIOD between rises is still a valid measurement.
    applyStimulus(5, 5, 1);
    checkOutput("p16_period", int'(period1), 16);
    checkOutput("p16_high", int'(high1), 8);
    checkOutput("p16_no_timeout", int'(to1), 0);
    checkOutput("p16_timeout_count", to_count, 1);

    // Short and long pulses.
    rise_before = rise_count;
    fall_before = fall_count;
    applyStimulus(2, 10, 1);
    checkOutput("short_pulse_rise", rise_count - rise_before, SHORT_TICKS);
    checkOutput("short_pulse_fall", fall_count - fall_before, SHORT_TICKS);
    rise_before = rise_count;
    fall_before = fall_count;
    applyStimulus(3, 10, 1);
    checkOutput("long_pulse_rise", rise_count - rise_before, 1);
    checkOutput("long_pulse_fall", fall_count - fall_before, 1);

    // Reset in the middle of a COUNT interval.
    applyStimulus(5, 5, 2);
    checkOutput("pre_reset_period", int'(period1), 10);
    @(negedge clk);
    sig_in = 1'b1;
    waitCycles(4);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_rise",    int'(rise1),   0);
    checkOutput("midreset_fall",    int'(fall1),   0);
    checkOutput("midreset_period",  int'(period1), 0);
    checkOutput("midreset_high",    int'(high1),   0);
    checkOutput("midreset_pv",      int'(pv1),     0);
    checkOutput("midreset_timeout", int'(to1),     0);
    checkOutput("midreset_locked",  int'(lock1),   0);
    pv_before = pv_count;
    waitCycles(2);
    sig_in = 1'b0;
    waitCycles(1);
    @(negedge clk);
    rst_n = 1'b1;
    waitCycles(5);
    applyStimulus(5, 5, 1);
    checkOutput("midreset_no_pv", pv_count, pv_before);
    checkOutput("midreset_period_after", int'(period1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
